dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h10010000, byte address of word 0.
REQ-002 Parameter DEPTH_WORDS, default 256, number of 32-bit words; power of two, 16..4096.
REQ-003 Parameter WAIT_CYCLES, default 2, wait states between accept and response; range 0..15.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  one clock; reset is synchronous and active-low (rst=0 resets on posedge clk).
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder accepts the request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_be  input  4  byte enables for stores, bit i = byte lane i (little-endian); ignored for loads.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator consumes the response.
REQ-014 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; exactly one active.
REQ-017 IDLE: req_ready=1, rsp_valid=0; on req_valid=1, accept, capture we/be/addr/wdata, load counter with WAIT_CYCLES.
REQ-018 On accept: go to WAIT if WAIT_CYCLES>0, else go to RESP.
REQ-019 WAIT: req_ready=0, rsp_valid=0; decrement counter each cycle; when counter reaches 1, commit the access and go to RESP.
REQ-020 Commit = store byte-lane writes or load read, evaluated on the cycle entering RESP; the response is registered.
REQ-021 With WAIT_CYCLES=N, rsp_valid rises exactly N+1 cycles after the accept edge.
REQ-022 RESP: rsp_valid=1, req_ready=0; rsp_rdata/rsp_err held stable until rsp_valid&&rsp_ready, then go to IDLE.
REQ-023 One request outstanding at most; no new accept in the cycle of the response handshake. Minimum period is N+2 cycles per transaction.
REQ-024 Word index = (req_addr-BASE_ADDR)>>2.
REQ-025 Error when req_addr[1:0]!=0, req_addr<BASE_ADDR, or the index is >=DEPTH_WORDS: no write, rsp_rdata=0, rsp_err=1.
REQ-026 Store: only lanes with req_be[i]=1 are updated; be=4'b0000 is a legal no-op; rsp_rdata=0, rsp_err=0.
REQ-027 Load returns the full word regardless of req_be.
REQ-028 A load of an address that was just stored returns the stored value; the store commits before any later accept.
REQ-029 Input changes while req_ready=0 are ignored. rsp_ready=1 outside RESP has no effect.

Reset
REQ-030 On rst=0 at posedge clk: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 on the first cycle after rst returns to 1.
REQ-031 Reset during WAIT aborts the request; an uncommitted store is not written.
REQ-032 Reset during RESP drops the response; a committed store remains.
REQ-033 The storage array is not cleared by reset and retains its contents.

Structure
REQ-034 Shared package mem_pkg holds the state enum (IDLE/WAIT/RESP), the default BASE_ADDR constant, and the data width/byte-enable width constants.
REQ-035 Sub-module dmem_array holds the word storage: one synchronous write port with 4 byte enables and one read port; the FSM, counter and address check sit in dmem_responder.

Verification
REQ-036 Store then load, WAIT_CYCLES=2: store addr 32'h10010008, data 32'hCAFEF00D, be 4'hF, then load the same address -> rsp_valid 3 cycles after each accept; load returns 32'hCAFEF00D with err=0.
REQ-037 Partial store: after the word holds 32'h11223344, store be=4'b0101 with data 32'hAABBCCDD -> load returns 32'h11BB33DD.
REQ-038 Errors: load at 32'h10010002 and at BASE_ADDR+4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0, no array change.
REQ-039 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1 with stable data, req_ready stays 0 and a new req_valid is not accepted; handshake on cycle 6 -> IDLE next cycle.
REQ-040 WAIT_CYCLES=0: back-to-back loads with rsp_ready tied to 1 -> rsp_valid 1 cycle after accept, one transaction every 2 cycles.
REQ-041 Reset mid-WAIT: store 32'h12345678 is accepted, then rst=0 in the WAIT cycle -> outputs reset, and a later load returns the prior contents.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// default memory placement and data/byte-enable widths.
package mem_pkg;

    localparam int          DATA_W            = 32;
    localparam int          BE_W              = DATA_W / 8;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with one byte-enabled synchronous write port and
// one asynchronous read port. Contents are never cleared.
module dmem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Update only the byte lanes whose enable is set
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one request, waits a
// fixed number of cycles, commits the access and holds a registered
// response until the initiator consumes it.
module dmem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [BE_W-1:0]   req_be,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        count;
    logic              cap_we;
    logic [BE_W-1:0]   cap_be;
    logic [31:0]       cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic              use_live;
    logic              commit;
    logic              op_we;
    logic [BE_W-1:0]   op_be;
    logic [31:0]       op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic [31:0]       op_offset;
    logic              op_err;
    logic [IDX_W-1:0]  op_index;
    logic [DATA_W-1:0] array_rdata;

    // With zero wait states the access commits on the accept edge itself,
    // so the operands come straight from the request inputs; otherwise
    // they come from the values captured at accept.
    assign use_live  = (state == IDLE);
    assign commit    = (use_live && req_valid && (WAIT_CYCLES == 0))
                     || (state == WAIT && count == 4'd1);
    assign op_we     = use_live ? req_we    : cap_we;
    assign op_be     = use_live ? req_be    : cap_be;
    assign op_addr   = use_live ? req_addr  : cap_addr;
    assign op_wdata  = use_live ? req_wdata : cap_wdata;

    // Misaligned, below the base, or past the last word are all errors
    assign op_offset = op_addr - BASE_ADDR;
    assign op_err    = (op_addr[1:0] != 2'b00)
                     || (op_addr < BASE_ADDR)
                     || ((op_offset >> 2) >= 32'(DEPTH_WORDS));
    assign op_index  = IDX_W'(op_offset >> 2);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (commit && op_we && !op_err),
        .be    (op_be),
        .waddr (op_index),
        .wdata (op_wdata),
        .raddr (op_index),
        .rdata (array_rdata)
    );

    // Request/response FSM with wait-state counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cap_we    <= 1'b0;
            cap_be    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            if (commit) begin
                rsp_rdata <= (op_we || op_err) ? '0 : array_rdata;
                rsp_err   <= op_err;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_be    <= req_be;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        count     <= WAIT_INIT;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (count == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        count     <= '0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
